bcd_entry_ctrl: RTL

Keypad-to-BCD entry stage. It collects up to three decimal digits of a target angle from the keypad scanner into a working buffer and supports backspace, clear and enter. On a valid enter it commits the hundreds/tens/units digits, which feed the downstream BCD-to-degrees converter directly. Out-of-range entries are rejected with a timed error flag, so the converter only ever sees hundreds in 0..2 and a value no greater than MAX_DEGREES.

---
 rtl/bcd_entry_pkg.sv | 29 ++
 rtl/bcd_entry_ctrl_if.sv | 24 ++
 rtl/bcd_entry_ctrl_key_edge_det.sv | 18 +
 rtl/bcd_entry_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/bcd_entry_pkg.sv
// Shared key codes, FSM state type and BCD helper for the keypad angle-entry path.
package bcd_entry_pkg;

    localparam logic [3:0] KEY_BKSP = 4'hA;
    localparam logic [3:0] KEY_CLR  = 4'hB;
    localparam logic [3:0] KEY_ENT  = 4'hC;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ENTRY,
        S_FULL,
        S_ERROR
    } entry_state_t;

    typedef struct packed {
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] u;
    } bcd3_t;

    function automatic bcd3_t to_bcd3(input int unsigned value);
        bcd3_t r;
        r.h = 4'((value / 100) % 10);
        r.t = 4'((value / 10) % 10);
        r.u = 4'(value % 10);
        return r;
    endfunction

endpackage

// File: rtl/bcd_entry_ctrl_if.sv
// Keypad-side inputs and converter/display-side outputs of the BCD entry stage.
interface bcd_entry_ctrl_if;

    logic        i_key_valid;
    logic [3:0]  i_key_code;
    logic [3:0]  o_units;
    logic [3:0]  o_tens;
    logic [3:0]  o_hundreds;
    logic        o_load;
    logic [11:0] o_work_bcd;
    logic [1:0]  o_digit_count;
    logic        o_error;

    modport master (
        output i_key_valid, i_key_code,
        input  o_units, o_tens, o_hundreds, o_load, o_work_bcd, o_digit_count, o_error
    );

    modport slave (
        input  i_key_valid, i_key_code,
        output o_units, o_tens, o_hundreds, o_load, o_work_bcd, o_digit_count, o_error
    );

endinterface

// File: rtl/bcd_entry_ctrl_key_edge_det.sv
// Rising-edge detector on the scanner key-present level: one accept strobe per press.
module key_edge_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_level,
    output logic o_strobe
);

    logic level_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) level_q <= 1'b0;
        else       level_q <= i_level;
    end

    assign o_strobe = i_level & ~level_q;

endmodule

// File: rtl/bcd_entry_ctrl.sv
// Keypad-to-BCD entry stage: three-digit working buffer, range-checked commit to the
// BCD-to-degrees converter, and a timed error flag for rejected entries.
module bcd_entry_ctrl
    import bcd_entry_pkg::*;
#(
    parameter int MAX_DEGREES     = 299,
    parameter int ERR_HOLD_CYCLES = 50_000_000
) (
    input logic             i_clk,
    input logic             i_rst,
    bcd_entry_ctrl_if.slave bus
);

    localparam bcd3_t MAX_BCD = to_bcd3(unsigned'(MAX_DEGREES));
    localparam int    TIMER_W = (ERR_HOLD_CYCLES > 1) ? $clog2(ERR_HOLD_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(ERR_HOLD_CYCLES - 1);

    if (MAX_DEGREES < 0 || MAX_DEGREES > 299) begin : g_bad_max
        $error("bcd_entry_ctrl: MAX_DEGREES must be within 0..299");
    end
    if (ERR_HOLD_CYCLES < 1) begin : g_bad_hold
        $error("bcd_entry_ctrl: ERR_HOLD_CYCLES must be at least 1");
    end

    entry_state_t       state_q, state_d;
    bcd3_t              buf_q, buf_d;
    bcd3_t              commit_q;
    logic [1:0]         count_q, count_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               error_q, error_d;
    logic               commit_pulse;
    logic               commit_dly_q;
    logic               load_q;
    logic               key_accept;
    logic [3:0]         key_code;
    logic               over_max;

    key_edge_det u_key_edge (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_level  (bus.i_key_valid),
        .o_strobe (key_accept)
    );

    assign key_code = bus.i_key_code;

    // Digit-wise magnitude compare; buffer digits are always 0..9 so this equals a numeric compare.
    assign over_max = (buf_q.h > MAX_BCD.h) ||
                      ((buf_q.h == MAX_BCD.h) &&
                       ((buf_q.t > MAX_BCD.t) ||
                        ((buf_q.t == MAX_BCD.t) && (buf_q.u > MAX_BCD.u))));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_EMPTY;
            buf_q   <= '0;
            count_q <= '0;
            timer_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            count_q <= count_d;
            timer_q <= timer_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        count_d      = count_q;
        timer_d      = timer_q;
        error_d      = error_q;
        commit_pulse = 1'b0;

        if (state_q == S_ERROR) begin
            if (key_accept && key_code == KEY_CLR) begin
                buf_d   = '0;
                count_d = '0;
                timer_d = '0;
                error_d = 1'b0;
                state_d = S_EMPTY;
            end else if (timer_q == '0) begin
                error_d = 1'b0;
                state_d = S_EMPTY;
            end else begin
                timer_d = timer_q - TIMER_W'(1);
            end
        end else if (key_accept) begin
            if (key_code <= 4'd9) begin
                if (state_q != S_FULL) begin
                    buf_d   = {buf_q.t, buf_q.u, key_code};
                    count_d = count_q + 2'd1;
                    state_d = (count_q == 2'd2) ? S_FULL : S_ENTRY;
                end
            end else if (key_code == KEY_BKSP) begin
                if (state_q != S_EMPTY) begin
                    buf_d   = {4'd0, buf_q.h, buf_q.t};
                    count_d = count_q - 2'd1;
                    state_d = (count_q == 2'd1) ? S_EMPTY : S_ENTRY;
                end
            end else if (key_code == KEY_CLR) begin
                buf_d   = '0;
                count_d = '0;
                state_d = S_EMPTY;
            end else if (key_code == KEY_ENT && state_q != S_EMPTY) begin
                buf_d   = '0;
                count_d = '0;
                if (over_max) begin
                    error_d = 1'b1;
                    timer_d = TIMER_LOAD;
                    state_d = S_ERROR;
                end else begin
                    commit_pulse = 1'b1;
                    state_d      = S_EMPTY;
                end
            end
        end
    end

    // o_load trails the commit register update by one cycle, hence the extra stage.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            commit_q     <= '0;
            commit_dly_q <= 1'b0;
            load_q       <= 1'b0;
        end else begin
            if (commit_pulse) commit_q <= buf_q;
            commit_dly_q <= commit_pulse;
            load_q       <= commit_dly_q;
        end
    end

    assign bus.o_hundreds    = commit_q.h;
    assign bus.o_tens        = commit_q.t;
    assign bus.o_units       = commit_q.u;
    assign bus.o_load        = load_q;
    assign bus.o_work_bcd    = buf_q;
    assign bus.o_digit_count = count_q;
    assign bus.o_error       = error_q;

endmodule
